// File: rtl/uart_pkg.sv
// Shared UART helpers: FIFO entry width and tag-bit position for received characters.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package uart_pkg;

    // One stored entry is the character plus a framing-error tag bit on top.
    function automatic int entry_width(input int data_bits);
        return data_bits + 1;
    endfunction

    // Index of the framing-error tag bit inside an entry ({ferr_tag, data}).
    function automatic int tag_bit(input int data_bits);
        return data_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read and extra-MSB pointers.
// Latency: write visible on rdata/count one cycle after push; rdata is combinational from the read pointer.
// Backpressure: push while full is discarded unless a pop happens in the same cycle; pop while empty is ignored.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only, storage is not reset)
//   clr             synchronous flush of both pointers
//   push, wdata     write request and entry
//   pop             read request (advances head)
//   rdata           head entry, valid while empty=0
//   count           number of stored entries
//   empty, full     status decoded from the pointers
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers carry one extra bit so equal low bits can be told apart as empty vs full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A push into a full FIFO is legal when the head leaves in the same cycle:
    // the write lands in the very slot being freed.
    assign rd_ok = pop & ~empty & ~clr;
    assign wr_ok = push & ~clr & (~full | rd_ok);

    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: queues received characters and framing-error tag entries, with sticky overflow and IRQs.
// Latency: a push shows in count/empty one cycle later; a frame-error tag colliding with data lands one cycle after the data.
// Backpressure: none toward the receiver; pushes while full (no pop) are dropped and set overflow. rd_en on empty is ignored.
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout counter;
// otherwise timeout_irq is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     low flushes the FIFO and all flags every cycle
//   baud_tick                  receiver oversample tick, drives the idle timeout
//   in_data, in_valid          received character and its one-cycle strobe
//   in_frame_err               receiver framing-error level; each rising edge queues a tag entry
//   rd_en, rd_data             pop request and show-ahead head entry {ferr_tag, data}
//   count, empty, full         fill status
//   overflow, clr_overflow     sticky dropped-write flag and its clear
//   thresh_irq, timeout_irq    fill-level and idle-timeout interrupts
module uart_rx_fifo #(
    parameter int DATA_BITS     = 8,
    parameter int DEPTH         = 16,
    parameter int THRESH        = 8,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     baud_tick,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic                     in_valid,
    input  logic                     in_frame_err,
    input  logic                     rd_en,
    output logic [DATA_BITS:0]       rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     thresh_irq,
    output logic                     timeout_irq
);

    import uart_pkg::*;

    localparam int EW      = entry_width(DATA_BITS);
    localparam int TAG_IDX = tag_bit(DATA_BITS);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    logic          ferr_q;
    logic          pend_q;
    logic          pend_d;
    logic          ovf_q;
    logic          ferr_edge;
    logic          tag_req;
    logic          push_req;
    logic          pop_req;
    logic          drop;
    logic          push_acc;
    logic [EW-1:0] wdata;

    assign ferr_edge = in_frame_err & ~ferr_q;
    assign tag_req   = ferr_edge | pend_q;

    // Data wins a collision with a tag; the tag waits in the one-deep pending flag.
    // Tag entries are all zeros except the tag bit.
    always_comb begin
        push_req = 1'b0;
        pend_d   = 1'b0;
        wdata    = '0;
        if (enable) begin
            if (in_valid) begin
                push_req                = 1'b1;
                wdata[DATA_BITS-1:0]    = in_data;
                pend_d                  = tag_req;
            end else if (tag_req) begin
                push_req                = 1'b1;
                wdata[TAG_IDX]          = 1'b1;
            end
        end
    end

    assign pop_req  = enable & rd_en & ~empty;
    assign drop     = push_req & full & ~pop_req;
    assign push_acc = push_req & ~drop;

    // Edge register resets to 1 so a frame error already high at reset release is not tagged.
    // It keeps tracking the line while disabled, so a level held across re-enable is not tagged either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b1;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ferr_q <= in_frame_err;
            if (!enable) begin
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                pend_q <= pend_d;
                // A new drop beats a simultaneous clear.
                if (drop)
                    ovf_q <= 1'b1;
                else if (clr_overflow)
                    ovf_q <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~enable),
        .push  (push_acc),
        .pop   (pop_req),
        .wdata (wdata),
        .rdata (rd_data),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign overflow   = ovf_q;
    assign thresh_irq = (count >= THRESH_C);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

    logic [TW-1:0] to_cnt;
    logic          to_irq;

    // Counts ticks of inactivity while data is waiting; saturates at the limit.
    // A push only restarts the count, a pop or an empty FIFO also drops the IRQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_irq <= 1'b0;
        end else if (!enable || empty || pop_req) begin
            to_cnt <= '0;
            to_irq <= 1'b0;
        end else if (push_acc) begin
            to_cnt <= '0;
        end else if (baud_tick && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) to_irq <= 1'b1;
        end
    end

    assign timeout_irq = to_irq;
`else
    logic unused_tick;
    assign unused_tick = baud_tick;
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       baud_tick;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_frame_err;
    logic       rd_en;
    logic [8:0] rd_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       clr_overflow;
    logic       thresh_irq;
    logic       timeout_irq;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       en;
        logic       vld;
        logic [7:0] d;
        logic       fe;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       thr;
        logic [8:0] rdd;
    } vec_t;

    vec_t vq[$];

    uart_rx_fifo #(
        .DATA_BITS     (8),
        .DEPTH         (16),
        .THRESH        (8),
        .TIMEOUT_TICKS (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .baud_tick    (baud_tick),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_frame_err (in_frame_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .thresh_irq   (thresh_irq),
        .timeout_irq  (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic add(input logic en, input logic vld, input logic [7:0] d, input logic fe,
                       input logic rd, input logic clr, input int cnt, input logic emp,
                       input logic ful, input logic ovf, input logic thr, input logic [8:0] rdd);
        vec_t v;
        v.en = en; v.vld = vld; v.d = d; v.fe = fe; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovf = ovf; v.thr = thr; v.rdd = rdd;
        vq.push_back(v);
    endtask

    // One clock with the given pulse inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic vld, input logic [7:0] d, input logic rd,
                        input logic clr, input logic tk);
        in_valid = vld; in_data = d; rd_en = rd; clr_overflow = clr; baud_tick = tk;
        @(posedge clk);
        #1;
        in_valid = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0; baud_tick = 1'b0;
    endtask

    initial begin
        logic [8:0] exp_q[$];

        rst_n = 1'b0; enable = 1'b1; baud_tick = 1'b0; in_data = '0; in_valid = 1'b0;
        in_frame_err = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_thresh", thresh_irq, 0);
        check("rst_timeout", timeout_irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        //   en vld  d    fe rd clr  cnt emp ful ovf thr rd_data
        // three pushes then three pops, then a pop on empty
        add(1, 1, 8'h41, 0, 0, 0,  1, 0, 0, 0, 0, 9'h041);
        add(1, 1, 8'h42, 0, 0, 0,  2, 0, 0, 0, 0, 9'h041);
        add(1, 1, 8'h43, 0, 0, 0,  3, 0, 0, 0, 0, 9'h041);
        add(1, 0, 8'h00, 0, 1, 0,  2, 0, 0, 0, 0, 9'h042);
        add(1, 0, 8'h00, 0, 1, 0,  1, 0, 0, 0, 0, 9'h043);
        add(1, 0, 8'h00, 0, 1, 0,  0, 1, 0, 0, 0, 9'h000);
        add(1, 0, 8'h00, 0, 1, 0,  0, 1, 0, 0, 0, 9'h000);
        // frame error edge colliding with data 0x55: data first, tag next cycle
        add(1, 1, 8'h55, 1, 0, 0,  1, 0, 0, 0, 0, 9'h055);
        add(1, 0, 8'h00, 1, 0, 0,  2, 0, 0, 0, 0, 9'h055);
        add(1, 0, 8'h00, 1, 1, 0,  1, 0, 0, 0, 0, 9'h100);
        add(1, 0, 8'h00, 0, 1, 0,  0, 1, 0, 0, 0, 9'h000);
        // lone edge makes one tag; a held level makes no more
        add(1, 0, 8'h00, 1, 0, 0,  1, 0, 0, 0, 0, 9'h100);
        add(1, 0, 8'h00, 1, 0, 0,  1, 0, 0, 0, 0, 9'h100);
        add(1, 0, 8'h00, 0, 1, 0,  0, 1, 0, 0, 0, 9'h000);
        // eight pushes reach the threshold, then a one-cycle disable flushes
        for (int k = 1; k <= 8; k++)
            add(1, 1, 8'(8'h10 + k - 1), 0, 0, 0, k, 0, 0, 0, (k >= 8), 9'h010);
        add(0, 0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 0, 9'h000);
        // while disabled, data is ignored
        add(0, 1, 8'h99, 0, 0, 0,  0, 1, 0, 0, 0, 9'h000);
        add(1, 0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 0, 9'h000);

        foreach (vq[i]) begin
            enable = vq[i].en; in_valid = vq[i].vld; in_data = vq[i].d;
            in_frame_err = vq[i].fe; rd_en = vq[i].rd; clr_overflow = vq[i].clr;
            baud_tick = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), count, vq[i].cnt);
            check($sformatf("v%0d_empty", i), empty, vq[i].emp);
            check($sformatf("v%0d_full", i), full, vq[i].ful);
            check($sformatf("v%0d_overflow", i), overflow, vq[i].ovf);
            check($sformatf("v%0d_thresh", i), thresh_irq, vq[i].thr);
            if (!vq[i].emp)
                check($sformatf("v%0d_rd_data", i), rd_data, vq[i].rdd);
        end
        enable = 1'b1; in_valid = 1'b0; rd_en = 1'b0; in_frame_err = 1'b0; clr_overflow = 1'b0;

        // ---------------- 17 pushes into 16 entries ----------------
        for (int k = 0; k < 17; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
        check("ovf17_count", count, 16);
        check("ovf17_full", full, 1);
        check("ovf17_overflow", overflow, 1);
        check("ovf17_thresh", thresh_irq, 1);
        check("ovf17_head", rd_data, 9'h000);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clr_overflow", overflow, 0);

        // a drop in the same cycle as a clear keeps overflow set
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check("clr_vs_drop_overflow", overflow, 1);
        check("clr_vs_drop_count", count, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clr_again", overflow, 0);

        // ---------------- push and pop while full ----------------
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        check("fullpp_count", count, 16);
        check("fullpp_full", full, 1);
        check("fullpp_overflow", overflow, 0);
        for (int k = 1; k < 16; k++) exp_q.push_back(9'(k));
        exp_q.push_back(9'h0AA);
        foreach (exp_q[k]) begin
            check($sformatf("drain%0d", k), rd_data, exp_q[k]);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // ---------------- idle timeout ----------------
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 63; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("timeout_63", timeout_irq, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        check("timeout_64", timeout_irq, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("timeout_saturated", timeout_irq, 1);
`else
        check("timeout_64", timeout_irq, 0);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("timeout_after_pop", timeout_irq, 0);
        check("timeout_pop_empty", empty, 1);

        // ---------------- frame error already high at reset release ----------------
        in_frame_err = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("ferr_at_reset_count", count, 0);
        check("ferr_at_reset_empty", empty, 1);
        in_frame_err = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
